// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder and its sequencer.
// Operation codes, R-type func codes, ALUOp classes and FSM states.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_LS  = 4'b0011;
    localparam logic [3:0] OP_SRS = 4'b0100;
    localparam logic [3:0] OP_URS = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_ROR = 4'b1000;
    localparam logic [3:0] OP_ROL = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_DIV = 4'b1011;
    localparam logic [3:0] OP_NOT = 4'b1111;

    localparam logic [5:0] F_ADD = 6'b000000;
    localparam logic [5:0] F_NOT = 6'b000001;
    localparam logic [5:0] F_SUB = 6'b000010;
    localparam logic [5:0] F_AND = 6'b000100;
    localparam logic [5:0] F_OR  = 6'b000101;
    localparam logic [5:0] F_SLT = 6'b001010;
    localparam logic [5:0] F_MUL = 6'b011000;
    localparam logic [5:0] F_DIV = 6'b011010;
    localparam logic [5:0] F_URS = 6'b111001;
    localparam logic [5:0] F_SRS = 6'b111010;
    localparam logic [5:0] F_ROR = 6'b111011;
    localparam logic [5:0] F_LS  = 6'b111101;
    localparam logic [5:0] F_ROL = 6'b111110;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_OUT  = 2'b10
    } state_t;

endpackage

// File: rtl/alu_func_decode.sv
// Combinational ALUOp/func decode into operation code, multi-cycle class and illegal flag.
// Unknown R-type func codes fall back to ADD and raise illegal.
module alu_func_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int FUNC_W = 6
) (
    input  logic [1:0]        alu_op,
    input  logic [FUNC_W-1:0] func,
    output logic [OP_W-1:0]   operation,
    output logic              multi_cycle,
    output logic              illegal
);

    always_comb begin
        operation   = OP_W'(OP_ADD);
        multi_cycle = 1'b0;
        illegal     = 1'b0;
        case (alu_op)
            ALUOP_ADD: operation = OP_W'(OP_ADD);
            ALUOP_SUB: operation = OP_W'(OP_SUB);
            ALUOP_SLT: operation = OP_W'(OP_SLT);
            ALUOP_RTYPE: begin
                case (func)
                    FUNC_W'(F_ADD): operation = OP_W'(OP_ADD);
                    FUNC_W'(F_SUB): operation = OP_W'(OP_SUB);
                    FUNC_W'(F_AND): operation = OP_W'(OP_AND);
                    FUNC_W'(F_OR):  operation = OP_W'(OP_OR);
                    FUNC_W'(F_SLT): operation = OP_W'(OP_SLT);
                    FUNC_W'(F_NOT): operation = OP_W'(OP_NOT);
                    FUNC_W'(F_LS):  operation = OP_W'(OP_LS);
                    FUNC_W'(F_SRS): operation = OP_W'(OP_SRS);
                    FUNC_W'(F_URS): operation = OP_W'(OP_URS);
                    FUNC_W'(F_ROR): operation = OP_W'(OP_ROR);
                    FUNC_W'(F_ROL): operation = OP_W'(OP_ROL);
                    FUNC_W'(F_MUL): begin
                        operation   = OP_W'(OP_MUL);
                        multi_cycle = 1'b1;
                    end
                    FUNC_W'(F_DIV): begin
                        operation   = OP_W'(OP_DIV);
                        multi_cycle = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: operation = OP_W'(OP_ADD);
        endcase
    end

endmodule

// File: rtl/alu_control_seq.sv
// Registered, handshaked ALU control: decodes on accept, holds the result until the ALU
// takes it, and stalls for MUL/DIV with a down-counter. CNT_W must cover max(MUL_LAT, DIV_LAT).
//
//   state   | meaning
//   IDLE    | nothing held, ready for a request
//   BUSY    | MUL/DIV executing, counter runs down to zero
//   OUT     | operation presented to the ALU, waiting for out_ready
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int FUNC_W  = 6,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        ALUOp,
    input  logic [FUNC_W-1:0] func,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   operation,
    output logic              multi_cycle,
    output logic              alu_start,
    output logic              illegal
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  load_lat;
    logic [OP_W-1:0]   dec_op;
    logic              dec_multi;
    logic              dec_illegal;
    logic              accept;

    logic [OP_W-1:0]   op_q;
    logic              multi_q;
    logic              illegal_q;
    logic              start_q;

    alu_func_decode #(
        .OP_W   (OP_W),
        .FUNC_W (FUNC_W)
    ) u_decode (
        .alu_op      (ALUOp),
        .func        (func),
        .operation   (dec_op),
        .multi_cycle (dec_multi),
        .illegal     (dec_illegal)
    );

    // Counter is loaded with LAT-1 so BUSY lasts exactly LAT cycles.
    assign load_lat = (dec_op == OP_W'(OP_DIV)) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_BUSY: begin
                if (cnt_q == '0) state_d = ST_OUT;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_OUT: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready && !in_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        accept = in_valid && in_ready;
        if (accept) begin
            state_d = dec_multi ? ST_BUSY : ST_OUT;
            if (dec_multi) cnt_d = load_lat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            multi_q   <= 1'b0;
            illegal_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            start_q <= accept && dec_multi;
            if (accept) begin
                op_q      <= dec_op;
                multi_q   <= dec_multi;
                illegal_q <= dec_illegal;
            end
        end
    end

    assign operation   = op_q;
    assign multi_cycle = multi_q;
    assign illegal     = illegal_q;
    assign alu_start   = start_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: decode vector table, hand-written timing
// sequences, then a random handshake stream against a cycle-level transaction model.
module tb_alu_control_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] ALUOp;
    logic [5:0] func;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] operation;
    logic       multi_cycle;
    logic       alu_start;
    logic       illegal;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_control_seq #(
        .OP_W(4), .FUNC_W(6), .MUL_LAT(4), .DIV_LAT(8), .CNT_W(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ALUOp       (ALUOp),
        .func        (func),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .operation   (operation),
        .multi_cycle (multi_cycle),
        .alu_start   (alu_start),
        .illegal     (illegal)
    );

    typedef struct {
        logic [1:0] alu_op;
        logic [5:0] fn;
        logic [3:0] op;
        logic       ill;
        logic       multi;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    // Reference map: legal func -> operation code; absent keys are illegal.
    int   ref_op[int];
    int   legal_funcs[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_op"},      32'(operation),   0);
        check({tag, "_valid"},   32'(out_valid),   0);
        check({tag, "_multi"},   32'(multi_cycle), 0);
        check({tag, "_start"},   32'(alu_start),   0);
        check({tag, "_illegal"}, 32'(illegal),     0);
        check({tag, "_ready"},   32'(in_ready),    1);
    endtask

    initial begin
        int n;
        int cyc;
        int seen;
        bit pending;
        int ready_at, start_at;
        int e_op, e_ill, e_multi;
        bit e_valid, e_ready;

        ref_op[6'b000000] = 4'b0010; ref_op[6'b000010] = 4'b0110;
        ref_op[6'b000100] = 4'b0000; ref_op[6'b000101] = 4'b0001;
        ref_op[6'b001010] = 4'b0111; ref_op[6'b000001] = 4'b1111;
        ref_op[6'b111101] = 4'b0011; ref_op[6'b111010] = 4'b0100;
        ref_op[6'b111001] = 4'b0101; ref_op[6'b111011] = 4'b1000;
        ref_op[6'b111110] = 4'b1001; ref_op[6'b011000] = 4'b1010;
        ref_op[6'b011010] = 4'b1011;
        foreach (ref_op[k]) legal_funcs.push_back(k);

        vecs.push_back('{2'b00, 6'b000000, 4'b0010, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b00, 6'b011000, 4'b0010, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b01, 6'b011010, 4'b0110, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b11, 6'b101010, 4'b0111, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b10, 6'b000000, 4'b0010, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b10, 6'b000010, 4'b0110, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b10, 6'b000100, 4'b0000, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b10, 6'b000101, 4'b0001, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b10, 6'b001010, 4'b0111, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b10, 6'b000001, 4'b1111, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b10, 6'b111101, 4'b0011, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b10, 6'b111010, 4'b0100, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b10, 6'b111001, 4'b0101, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b10, 6'b111011, 4'b1000, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b10, 6'b111110, 4'b1001, 1'b0, 1'b0, 1});
        vecs.push_back('{2'b10, 6'b011000, 4'b1010, 1'b0, 1'b1, 5});
        vecs.push_back('{2'b10, 6'b011010, 4'b1011, 1'b0, 1'b1, 9});
        vecs.push_back('{2'b10, 6'b101010, 4'b0010, 1'b1, 1'b0, 1});
        vecs.push_back('{2'b10, 6'b111111, 4'b0010, 1'b1, 1'b0, 1});

        // Reset, then a single R-type ADD.
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ALUOp = 2'b00; func = 6'b0;
        tick(); tick();
        check_reset_values("reset");
        rst = 1'b0;
        ALUOp = 2'b10; func = 6'b000000; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        check("add_valid",   32'(out_valid), 1);
        check("add_op",      32'(operation), 4'b0010);
        check("add_illegal", 32'(illegal),   0);
        in_valid = 1'b0;
        tick();
        check("add_drain", 32'(out_valid), 0);

        // Decode table, each request issued from IDLE.
        foreach (vecs[i]) begin
            ALUOp = vecs[i].alu_op; func = vecs[i].fn; in_valid = 1'b1; out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < 20) begin
                tick();
                n++;
            end
            check($sformatf("vec%0d_lat", i),     n,                   vecs[i].lat);
            check($sformatf("vec%0d_op", i),      32'(operation),      32'(vecs[i].op));
            check($sformatf("vec%0d_illegal", i), 32'(illegal),        32'(vecs[i].ill));
            check($sformatf("vec%0d_multi", i),   32'(multi_cycle),    32'(vecs[i].multi));
            tick();
        end

        // Back-to-back stream with no bubbles.
        in_valid = 1'b1; out_ready = 1'b1;
        ALUOp = 2'b01; tick();
        check("b2b0_valid", 32'(out_valid), 1); check("b2b0_op", 32'(operation), 4'b0110);
        ALUOp = 2'b11; tick();
        check("b2b1_valid", 32'(out_valid), 1); check("b2b1_op", 32'(operation), 4'b0111);
        ALUOp = 2'b10; func = 6'b111011; tick();
        check("b2b2_valid", 32'(out_valid), 1); check("b2b2_op", 32'(operation), 4'b1000);
        in_valid = 1'b0; tick();
        check("b2b_idle", 32'(out_valid), 0);

        // MUL timing, with requests offered during BUSY that must be ignored.
        ALUOp = 2'b10; func = 6'b011000; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        check("mul_start1", 32'(alu_start), 1);
        check("mul_ready1", 32'(in_ready),  0);
        check("mul_valid1", 32'(out_valid), 0);
        ALUOp = 2'b01; func = 6'b000000;
        for (int c = 2; c <= 4; c++) begin
            if (c == 4) in_valid = 1'b0;
            tick();
            check($sformatf("mul_start%0d", c), 32'(alu_start), 0);
            check($sformatf("mul_ready%0d", c), 32'(in_ready),  0);
            check($sformatf("mul_valid%0d", c), 32'(out_valid), 0);
        end
        tick();
        check("mul_valid5", 32'(out_valid),   1);
        check("mul_op5",    32'(operation),   4'b1010);
        check("mul_multi5", 32'(multi_cycle), 1);
        tick();
        check("mul_idle", 32'(out_valid), 0);

        // Backpressure: held output, a competing request must not be taken.
        ALUOp = 2'b01; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        ALUOp = 2'b11;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp%0d_valid", c), 32'(out_valid), 1);
            check($sformatf("bp%0d_op", c),    32'(operation), 4'b0110);
            check($sformatf("bp%0d_ready", c), 32'(in_ready),  0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1; #1;
        check("bp_release_ready", 32'(in_ready), 1);
        tick();
        check("bp_idle", 32'(out_valid), 0);

        // Illegal then legal, back to back.
        ALUOp = 2'b10; func = 6'b101010; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        check("ill_op", 32'(operation), 4'b0010); check("ill_flag", 32'(illegal), 1);
        check("ill_valid", 32'(out_valid), 1);
        func = 6'b000100;
        tick();
        check("and_op", 32'(operation), 4'b0000); check("and_flag", 32'(illegal), 0);
        in_valid = 1'b0; tick();

        // Reset in the middle of a DIV.
        ALUOp = 2'b10; func = 6'b011010; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("divrst");
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) seen++;
            tick();
        end
        check("divrst_no_valid", seen, 0);
        ALUOp = 2'b00; in_valid = 1'b1;
        tick();
        check("divrst_add_valid", 32'(out_valid), 1);
        check("divrst_add_op",    32'(operation), 4'b0010);
        in_valid = 1'b0;
        tick();

        // Random stream against a transaction/timing model.
        pending = 1'b0; ready_at = 0; start_at = -1; e_op = 0; e_ill = 0; e_multi = 0;
        cyc = 0;
        for (int it = 0; it < 2000; it++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            ALUOp     = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                func = 6'(legal_funcs[$urandom_range(0, legal_funcs.size() - 1)]);
            else
                func = 6'($urandom_range(0, 63));
            #1;
            e_valid = pending && (cyc >= ready_at);
            e_ready = !pending || (e_valid && out_ready);
            check("rnd_ready", 32'(in_ready),  32'(e_ready));
            check("rnd_valid", 32'(out_valid), 32'(e_valid));
            check("rnd_start", 32'(alu_start), (cyc == start_at) ? 1 : 0);
            if (e_valid) begin
                check("rnd_op",      32'(operation),   e_op);
                check("rnd_illegal", 32'(illegal),     e_ill);
                check("rnd_multi",   32'(multi_cycle), e_multi);
            end
            if (e_valid && out_ready) pending = 1'b0;
            if (in_valid && e_ready) begin
                pending = 1'b1;
                e_ill = 0; e_multi = 0;
                if (ALUOp == 2'b00)      e_op = 4'b0010;
                else if (ALUOp == 2'b01) e_op = 4'b0110;
                else if (ALUOp == 2'b11) e_op = 4'b0111;
                else if (ref_op.exists(int'(func))) e_op = ref_op[int'(func)];
                else begin
                    e_op = 4'b0010; e_ill = 1;
                end
                if (e_op == 4'b1010) begin
                    e_multi = 1; ready_at = cyc + 1 + 4; start_at = cyc + 1;
                end else if (e_op == 4'b1011) begin
                    e_multi = 1; ready_at = cyc + 1 + 8; start_at = cyc + 1;
                end else begin
                    ready_at = cyc + 1; start_at = -1;
                end
            end
            tick();
            cyc++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
